// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared constants and segment-centre helper for the approximate multiplier.
package approx_mul_pkg;
  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;
  localparam int   CNT_W       = 16;

  // Keep the top K bits, set the next bit, clear the rest: midpoint of the operand's segment.
  function automatic logic [31:0] seg_centre(input logic [31:0] value, input int w, input int k);
    logic [31:0] hi;
    hi = (value >> (w - k)) << (w - k);
    return hi | (32'd1 << (w - k - 1));
  endfunction
endpackage

// File: rtl/approx_mul_core.sv
// approx_mul_core: combinational partial products feeding S1 and sum/clamp feeding S2.
module approx_mul_core import approx_mul_pkg::*; #(
  parameter int W = 8,
  parameter int K = 1
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           mode,
  output logic [2*W-1:0] p0,
  output logic [2*W-1:0] p1,
  output logic [2*W-1:0] p2,
  input  logic [2*W-1:0] q0,
  input  logic [2*W-1:0] q1,
  input  logic [2*W-1:0] q2,
  input  logic           q_mode,
  output logic [2*W-1:0] z,
  output logic           clamped
);
  localparam int PW = 2 * W;
  logic [PW-1:0] xe, ye, cxe, cye;
  logic [PW+1:0] zs;
  logic          neg, ovf;

  always_comb begin
    xe  = PW'(x);
    ye  = PW'(y);
    cxe = PW'(seg_centre(32'(x), W, K));
    cye = PW'(seg_centre(32'(y), W, K));
    p0  = mode == MODE_EXACT ? xe * ye : xe * cye;
    p1  = mode == MODE_EXACT ? '0 : ye * cxe;
    p2  = mode == MODE_EXACT ? '0 : cxe * cye;
    // Sum of two 2W-bit terms never reaches bit PW+1, so that bit is the sign.
    zs  = (PW+2)'(q0) + (PW+2)'(q1) - (PW+2)'(q2);
    neg = zs[PW+1];
    ovf = !zs[PW+1] && zs[PW];
    clamped = q_mode == MODE_APPROX && (neg || ovf);
    z = !clamped ? zs[PW-1:0] : neg ? '0 : '1;
  end
endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: 3-stage valid/ready approximate/exact multiplier with clamp counter.
module approx_mul_pipe import approx_mul_pkg::*; #(
  parameter int W     = 8,
  parameter int K     = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_z,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_clamped,
  output logic [CNT_W-1:0] clamp_count,
  input  logic             cnt_clr
);
  typedef struct packed {
    logic             v;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic             mode;
    logic [TAG_W-1:0] tag;
  } s0_t;
  typedef struct packed {
    logic             v;
    logic [2*W-1:0]   p0;
    logic [2*W-1:0]   p1;
    logic [2*W-1:0]   p2;
    logic             mode;
    logic [TAG_W-1:0] tag;
  } s1_t;
  typedef struct packed {
    logic             v;
    logic [2*W-1:0]   z;
    logic             clamped;
    logic [TAG_W-1:0] tag;
  } s2_t;

  s0_t s0_q, s0_d;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   p0, p1, p2, z;
  logic             clamped, adv;

  approx_mul_core #(.W(W), .K(K)) u_core (
    .x(s0_q.x), .y(s0_q.y), .mode(s0_q.mode),
    .p0(p0), .p1(p1), .p2(p2),
    .q0(s1_q.p0), .q1(s1_q.p1), .q2(s1_q.p2), .q_mode(s1_q.mode),
    .z(z), .clamped(clamped)
  );

  // One global enable: the whole pipe freezes while the output is held.
  always_comb begin
    adv   = !s2_q.v || out_ready;
    s0_d  = adv ? {in_valid, in_x, in_y, in_mode, in_tag} : s0_q;
    s1_d  = adv ? {s0_q.v, p0, p1, p2, s0_q.mode, s0_q.tag} : s1_q;
    s2_d  = adv ? {s1_q.v, z, clamped, s1_q.tag} : s2_q;
    cnt_d = cnt_clr ? '0 :
            (s2_q.v && out_ready && s2_q.clamped && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready    = adv;
  assign out_valid   = s2_q.v;
  assign out_z       = s2_q.z;
  assign out_tag     = s2_q.tag;
  assign out_clamped = s2_q.clamped;
  assign clamp_count = cnt_q;
endmodule

// File: doc/approx_mul_pipe.md
# approx_mul_pipe

Pipelined, parametrised unsigned approximate multiplier for the unsigned-multiplier library. It generalises the fixed 8×8 planar approximation to W-bit operands and 2^K segments per operand. Each transaction selects approximate or exact mode, and the datapath sits behind a valid/ready stream with full backpressure. A saturating counter of clamped results is kept for error-statistics runs.

## Interface
- W, default 8: operand width, legal 4..16.
- K, default 1: segment-index bits per operand, legal 1..W-2.
- TAG_W, default 4: width of the sideband tag carried alongside each operand pair.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage 0 can accept.
- in_x  in  W  unsigned operand x.
- in_y  in  W  unsigned operand y.
- in_mode  in  1  0 = approximate, 1 = exact.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_z  out  2W  product or approximation.
- out_tag  out  TAG_W  tag of this result.
- out_clamped  out  1  result was clamped (approximate mode only).
- clamp_count  out  16  saturating count of clamped results delivered.
- cnt_clr  in  1  synchronous clear of clamp_count.

## Operation
- Segment centre per operand: cx = {x[W-1:W-K], 1'b1, (W-K-1) zeros}. Same rule gives cy from y.
- Approximate mode: z_s = x·cy + y·cx − cx·cy. This is the tangent plane of x·y at the segment centre.
  - Evaluate signed at 2W+2 bits.
  - If z_s < 0: out_z = 0, out_clamped = 1.
  - If z_s > 2^(2W)−1: out_z = all ones, out_clamped = 1.
  - Otherwise out_z = z_s[2W-1:0].
- Exact mode: out_z = x·y and out_clamped = 0.
- Pipeline stages:
  - S0 registers the inputs.
  - S1 registers the three partial products, or x·y plus zeros in exact mode.
  - S2 registers the sum and clamp result, and drives the outputs.
- Each stage carries valid, mode and tag.
- clamp_count increments by 1 on each out_valid && out_ready beat with out_clamped = 1. It holds at 0xFFFF.
- cnt_clr has priority over an increment in the same cycle.

## Timing
- Global advance enable: adv = !out_valid || out_ready. All stage registers load only when adv = 1.
- in_ready = adv, which is combinational from out_ready and out_valid.
- An input is accepted when in_valid && in_ready.
- Latency is 3 cycles from acceptance to out_valid with no stall.
- Throughput is 1 per cycle while out_ready = 1.
- Bubbles are not collapsed: an empty stage still waits for adv.
- While out_valid && !out_ready:
  - out_z, out_tag and out_clamped are held stable.
  - No stage moves and in_ready = 0.
- Reset values: all stage valids 0, out_valid 0, out_z 0, out_tag 0, out_clamped 0, clamp_count 0.
  - in_ready is 1 after reset.
- Reset asserted mid-operation discards all in-flight transactions. No partial result appears after rst_n deasserts.
- Simultaneous accept at input and deliver at output in the same cycle is legal and required for full throughput.

## Structure
- Package approx_mul_pkg holds:
  - mode encoding constants (MODE_APPROX = 0, MODE_EXACT = 1);
  - a function seg_centre(value, W, K);
  - the clamp counter width constant (16).
- One natural sub-module: approx_mul_core.
  - Purely combinational S1/S2 arithmetic: partial products, sum, clamp.
  - The top level owns the handshake, pipeline registers and counter.

## Test plan
- W=8, K=1, approx, x=100, y=200: out_z = 19712 after 3 cycles, out_clamped = 0. Same in exact mode: out_z = 20000.
- W=8, K=1, approx, x=0, y=0: z_s = −4096, so out_z = 0, out_clamped = 1, clamp_count = 1.
- W=8, K=1, approx, x=255, y=255: out_z = 61056. Exact mode: 65025.
- Stream 16 back-to-back mixed-mode pairs with out_ready low for cycles 5–8:
  - all 16 results arrive in order with correct tags;
  - outputs stay stable while stalled;
  - in_ready = 0 during the stall.
- Assert rst_n low with 3 transactions in flight: no outputs after release, clamp_count = 0. A fresh x=3, y=5 exact gives 15.
- W=12, K=3 random sweep against a reference model. Also check cnt_clr coinciding with a clamped delivery leaves clamp_count = 0.
